pattern_sequencer: RTL and testbench

Frame-level controller for the WatPixels pattern generators. It owns the shared `next_frame` animation strobe and its speed setting. It selects which of `NUM_PATTERNS` generators drives the VGA output, advancing on button press or after an automatic dwell period, with a blanked transition between patterns. It sits between the VGA timing block and the pattern generators, and its registered `rgb_out` feeds the output pins.

---
 rtl/watpixels_pkg.sv | 35 +++
 rtl/btn_sync_edge.sv | 33 +++
 rtl/pattern_sequencer.sv | 143 ++++++++++++++
 tb/tb_pattern_sequencer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/watpixels_pkg.sv
// Shared WatPixels definitions: sequencer state encoding, colour width,
// animation speed-code-to-divisor mapping and nominal frame geometry.
package watpixels_pkg;

   typedef enum logic {
      SHOW  = 1'b0,
      BLANK = 1'b1
   } seq_state_t;

   localparam int RGB_W = 6;

   // Nominal visible frame geometry driven by the VGA timing block.
   localparam int H_ACTIVE = 640;
   localparam int V_ACTIVE = 480;

   // Animation strobe divisors, indexed by speed code.
   localparam int SPEED0_DIV = 8;
   localparam int SPEED1_DIV = 4;
   localparam int SPEED2_DIV = 2;
   localparam int SPEED3_DIV = 1;

   // Divisors are powers of two, so "div_cnt mod divisor == 0" reduces to
   // masking div_cnt with (divisor-1).
   function automatic logic [2:0] speed_mask(input logic [1:0] speed);
      int div;
      case (speed)
         2'd0:    div = SPEED0_DIV;
         2'd1:    div = SPEED1_DIV;
         2'd2:    div = SPEED2_DIV;
         default: div = SPEED3_DIV;
      endcase
      return 3'(div - 1);
   endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchroniser plus registered rising-edge detector for an already
// debounced push-button level.
// Ports:
//   clk   - pixel clock
//   rst   - asynchronous active-high reset
//   btn   - asynchronous button level
//   pulse - one-cycle pulse, high 3 cycles after btn rises
module btn_sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic pulse
);

   logic meta;
   logic sync;
   logic sync_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta   <= 1'b0;
         sync   <= 1'b0;
         sync_q <= 1'b0;
         pulse  <= 1'b0;
      end else begin
         meta   <= btn;
         sync   <= meta;
         sync_q <= sync;
         pulse  <= sync & ~sync_q;
      end
   end

endmodule

// File: rtl/pattern_sequencer.sv
// Frame-level controller for the WatPixels pattern generators. Generates the
// shared next_frame animation strobe at a selectable rate, handles pause, and
// steps through NUM_PATTERNS generators (manual button or dwell timeout) with
// BLANK_FRAMES black frames inserted on every switch.
// Ports:
//   clk, rst        - pixel clock, asynchronous active-high reset
//   x, y            - current pixel position from VGA timing
//   btn_next        - advance to next pattern (debounced level)
//   btn_speed       - cycle animation speed (debounced level)
//   btn_pause       - toggle animation freeze (debounced level)
//   auto_en         - enable dwell-based auto advance
//   patterns_rgb    - packed generator colours, generator i at [6i+5:6i]
//   next_frame      - one-cycle animation strobe
//   pattern_sel     - displayed pattern index
//   speed_level     - current speed code
//   paused          - animation frozen
//   rgb_out         - registered output colour
module pattern_sequencer
   import watpixels_pkg::*;
#(
   parameter int NUM_PATTERNS = 4,
   parameter int DWELL_FRAMES = 600,
   parameter int BLANK_FRAMES = 8
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [9:0]                     x,
   input  logic [9:0]                     y,
   input  logic                           btn_next,
   input  logic                           btn_speed,
   input  logic                           btn_pause,
   input  logic                           auto_en,
   input  logic [RGB_W*NUM_PATTERNS-1:0]  patterns_rgb,
   output logic                           next_frame,
   output logic [2:0]                     pattern_sel,
   output logic [1:0]                     speed_level,
   output logic                           paused,
   output logic [RGB_W-1:0]               rgb_out
);

   localparam logic [15:0] DWELL_LAST = 16'(DWELL_FRAMES - 1);
   localparam logic [7:0]  BLANK_LAST = 8'(BLANK_FRAMES - 1);
   localparam logic [2:0]  SEL_LAST   = 3'(NUM_PATTERNS - 1);

   logic       next_pulse;
   logic       speed_pulse;
   logic       pause_pulse;

   logic       sof;
   logic       sof_q;
   logic       frame_tick;

   seq_state_t state;
   logic [2:0]  div_cnt;
   logic [15:0] dwell_cnt;
   logic [7:0]  blank_cnt;
   logic [RGB_W-1:0] sel_rgb;
   logic        dwell_done;

   btn_sync_edge u_next  (.clk(clk), .rst(rst), .btn(btn_next),  .pulse(next_pulse));
   btn_sync_edge u_speed (.clk(clk), .rst(rst), .btn(btn_speed), .pulse(speed_pulse));
   btn_sync_edge u_pause (.clk(clk), .rst(rst), .btn(btn_pause), .pulse(pause_pulse));

   assign sof = (x == 10'd0) && (y == 10'd0);

   // Only the first cycle of a (possibly multi-cycle) sof produces a tick.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sof_q      <= 1'b0;
         frame_tick <= 1'b0;
      end else begin
         sof_q      <= sof;
         frame_tick <= sof & ~sof_q;
      end
   end

   always_comb begin
      sel_rgb = '0;
      for (int i = 0; i < NUM_PATTERNS; i++)
         if (pattern_sel == 3'(i))
            sel_rgb = patterns_rgb[i*RGB_W +: RGB_W];
   end

   // Expiry looks only at auto_en and the count; pause freezes counting but
   // a count already sitting at the last frame still fires on the next tick.
   assign dwell_done = frame_tick && auto_en && (dwell_cnt == DWELL_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= SHOW;
         pattern_sel <= 3'd0;
         speed_level <= 2'd3;
         paused      <= 1'b0;
         next_frame  <= 1'b0;
         rgb_out     <= '0;
         div_cnt     <= 3'd0;
         dwell_cnt   <= 16'd0;
         blank_cnt   <= 8'd0;
      end else begin
         next_frame <= frame_tick && (state == SHOW) && !paused &&
                       ((div_cnt & speed_mask(speed_level)) == 3'd0);

         // A speed change restarts the divider so the new rate starts in phase.
         if (speed_pulse) begin
            speed_level <= speed_level + 2'd1;
            div_cnt     <= 3'd0;
         end else if (frame_tick) begin
            div_cnt <= div_cnt + 3'd1;
         end

         if (pause_pulse)
            paused <= ~paused;

         rgb_out <= (state == SHOW) ? sel_rgb : '0;

         case (state)
            SHOW: begin
               if (frame_tick && auto_en && !paused)
                  dwell_cnt <= dwell_cnt + 16'd1;
               // Button and expiry together still produce one transition.
               if (next_pulse || dwell_done) begin
                  state     <= BLANK;
                  blank_cnt <= 8'd0;
               end
            end
            BLANK: begin
               // btn_next is deliberately not looked at here: dropped, not queued.
               if (frame_tick) begin
                  if (blank_cnt == BLANK_LAST) begin
                     state       <= SHOW;
                     dwell_cnt   <= 16'd0;
                     pattern_sel <= (pattern_sel == SEL_LAST) ? 3'd0 : pattern_sel + 3'd1;
                  end else begin
                     blank_cnt <= blank_cnt + 8'd1;
                  end
               end
            end
            default: state <= SHOW;
         endcase
      end
   end

endmodule

// File: tb/tb_pattern_sequencer.sv
// Randomised scoreboard bench for pattern_sequencer. Short synthetic frames
// (FL cycles, sof held 1..3 cycles) drive a frame-level reference model; each
// clock edge's expected outputs are queued and a negedge monitor compares.
module tb_pattern_sequencer;

   localparam int NP = 4;
   localparam int DW = 4;
   localparam int BF = 2;
   localparam int FL = 12;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [9:0]    x = 10'd1;
   logic [9:0]    y = 10'd1;
   logic          btn_next = 1'b0;
   logic          btn_speed = 1'b0;
   logic          btn_pause = 1'b0;
   logic          auto_en = 1'b0;
   logic [6*NP-1:0] patterns_rgb = '0;
   logic          next_frame;
   logic [2:0]    pattern_sel;
   logic [1:0]    speed_level;
   logic          paused;
   logic [5:0]    rgb_out;

   pattern_sequencer #(.NUM_PATTERNS(NP), .DWELL_FRAMES(DW), .BLANK_FRAMES(BF)) dut (
      .clk(clk), .rst(rst), .x(x), .y(y),
      .btn_next(btn_next), .btn_speed(btn_speed), .btn_pause(btn_pause),
      .auto_en(auto_en), .patterns_rgb(patterns_rgb),
      .next_frame(next_frame), .pattern_sel(pattern_sel),
      .speed_level(speed_level), .paused(paused), .rgb_out(rgb_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      int nf;
      int sel;
      int spd;
      int pau;
      int rgb;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad = 0;
   int   nf_seen = 0;

   // reference model state
   bit   m_show;
   int   m_sel, m_spd, m_div, m_dwell, m_blank;
   bit   m_pau;
   bit   sof_h[5];
   bit   bh[3][5];   // 0 next, 1 speed, 2 pause; [k] = level k edges ago
   int   hold[3];

   task automatic chk(input string nm, input int got, input int want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d t=%0t", nm, got, want, $time);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (next_frame === 1'b1) nf_seen++;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("next_frame",  int'(next_frame),  e.nf);
         chk("pattern_sel", int'(pattern_sel), e.sel);
         chk("speed_level", int'(speed_level), e.spd);
         chk("paused",      int'(paused),      e.pau);
         chk("rgb_out",     int'(rgb_out),     e.rgb);
      end
   end

   task automatic model_reset();
      m_show = 1; m_sel = 0; m_spd = 3; m_div = 0;
      m_dwell = 0; m_blank = 0; m_pau = 0;
      for (int k = 0; k < 5; k++) begin
         sof_h[k] = 0;
         for (int b = 0; b < 3; b++) bh[b][k] = 0;
      end
      for (int b = 0; b < 3; b++) hold[b] = 0;
   endtask

   // One clock edge of the reference model, fed the levels sampled at it.
   task automatic model_edge(input bit sofv, input bit bn, input bit bs, input bit bp,
                             input logic [6*NP-1:0] pat);
      exp_t e;
      bit   tick, pn, ps, pp, old_pau, old_show;
      for (int k = 4; k > 0; k--) begin
         sof_h[k] = sof_h[k-1];
         for (int b = 0; b < 3; b++) bh[b][k] = bh[b][k-1];
      end
      sof_h[0] = sofv; bh[0][0] = bn; bh[1][0] = bs; bh[2][0] = bp;
      // sof seen one edge ago (and not two) is the tick acted on now;
      // a button rise three edges ago is the pulse acted on now.
      tick = sof_h[1] && !sof_h[2];
      pn = bh[0][3] && !bh[0][4];
      ps = bh[1][3] && !bh[1][4];
      pp = bh[2][3] && !bh[2][4];
      old_pau = m_pau;
      old_show = m_show;

      e.rgb = old_show ? int'((pat >> (6*m_sel)) & 24'h3f) : 0;
      e.nf  = (tick && old_show && !old_pau && (m_div % (8 >> m_spd)) == 0) ? 1 : 0;

      if (ps) begin m_spd = (m_spd + 1) % 4; m_div = 0; end
      else if (tick) m_div = (m_div + 1) % 8;
      if (pp) m_pau = !m_pau;

      if (old_show) begin
         bit expire;
         expire = tick && auto_en && (m_dwell == DW - 1);
         if (tick && auto_en && !old_pau) m_dwell++;
         if (pn || expire) begin m_show = 0; m_blank = 0; end
      end else if (tick) begin
         if (m_blank == BF - 1) begin
            m_show = 1; m_dwell = 0; m_sel = (m_sel + 1) % NP;
         end else m_blank++;
      end

      e.sel = m_sel; e.spd = m_spd; e.pau = m_pau ? 1 : 0;
      exp_q.push_back(e);
   endtask

   task automatic cycle(input bit sofv);
      bit b[3];
      if (sofv) begin x = 10'd0; y = 10'd0; end
      else begin
         x = 10'($urandom_range(1, 639));
         y = 10'($urandom_range(0, 479));
      end
      for (int i = 0; i < 3; i++) begin
         b[i] = (hold[i] > 0);
         if (hold[i] > 0) hold[i]--;
      end
      btn_next = b[0]; btn_speed = b[1]; btn_pause = b[2];
      patterns_rgb = 24'($urandom());
      @(posedge clk);
      model_edge(sofv, b[0], b[1], b[2], patterns_rgb);
      #1;
   endtask

   // act: 0 none, 1 next, 2 speed, 3 pause (mid-frame),
   //      4 next timed so its pulse lands on the following frame tick
   task automatic run_frame(input int act);
      int slen;
      slen = $urandom_range(1, 3);
      for (int c = 0; c < FL; c++) begin
         if (c == 4 && act >= 1 && act <= 3) hold[act-1] = 3;
         if (c == FL - 2 && act == 4) hold[0] = 3;
         cycle(c < slen);
      end
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_next_frame"},  int'(next_frame),  0);
      chk({tag, "_pattern_sel"}, int'(pattern_sel), 0);
      chk({tag, "_speed_level"}, int'(speed_level), 3);
      chk({tag, "_paused"},      int'(paused),      0);
      chk({tag, "_rgb_out"},     int'(rgb_out),     0);
   endtask

   initial begin
      int snap, sel0, guard;
      model_reset();
      #2 rst = 1'b1;
      #1 check_reset("init");
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;

      // speed 3: strobe every frame
      auto_en = 1'b0;
      repeat (4) run_frame(0);

      // speed 3 -> 0: strobes on frames 1 and 9 of the next 16
      run_frame(2);
      snap = nf_seen;
      repeat (16) run_frame(0);
      chk("speed0_strobe_count", nf_seen - snap, 2);
      chk("speed0_level", int'(speed_level), 0);
      repeat (3) run_frame(2);

      // auto advance through all patterns and past the wrap
      auto_en = 1'b1;
      repeat (26) run_frame(0);

      // btn_next coincident with dwell expiry
      guard = 0;
      while (!(m_show && m_dwell == DW - 2 && !m_pau) && guard < 20) begin
         run_frame(0); guard++;
      end
      sel0 = m_sel;
      run_frame(4);
      repeat (3) run_frame(0);
      chk("coincident_single_adv", int'(pattern_sel), (sel0 + 1) % NP);

      // btn_next while already blanking
      guard = 0;
      while (!(m_show && m_dwell == DW - 1) && guard < 20) begin
         run_frame(0); guard++;
      end
      sel0 = m_sel;
      run_frame(1);
      repeat (2) run_frame(0);
      chk("next_in_blank_single_adv", int'(pattern_sel), (sel0 + 1) % NP);

      // pause, manual advance while paused, resume
      run_frame(3);
      snap = nf_seen;
      repeat (6) run_frame(0);
      chk("paused_no_strobe", nf_seen - snap, 0);
      run_frame(1);
      repeat (4) run_frame(0);
      run_frame(3);
      repeat (4) run_frame(0);

      // auto_en dropped mid-dwell, then restored
      auto_en = 1'b0;
      repeat (5) run_frame(0);
      auto_en = 1'b1;
      repeat (5) run_frame(0);

      // randomised mix
      for (int f = 0; f < 40; f++) begin
         if (f % 13 == 5) auto_en = ~auto_en;
         run_frame($urandom_range(0, 6) > 4 ? 0 : $urandom_range(0, 4));
      end

      // asynchronous reset in the middle of a blank
      auto_en = 1'b1;
      guard = 0;
      while (!m_show && guard < 10) begin run_frame(0); guard++; end
      run_frame(2);
      run_frame(1);
      @(posedge clk);
      #2 rst = 1'b1;
      #1 check_reset("rst_mid_blank");
      x = 10'd5; y = 10'd5;
      btn_next = 1'b0; btn_speed = 1'b0; btn_pause = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      auto_en = 1'b0;
      repeat (3) run_frame(0);
      chk("post_reset_sel", int'(pattern_sel), 0);

      @(negedge clk);
      @(negedge clk);
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
